// File: rtl/zbuf_fill_engine.sv
// zbuf_fill_engine: fetches one 4x4 z-block (8 x 32-bit words) from main memory
// and streams it, in word order, into the z-buffer cache line-fill port.
module zbuf_fill_engine #(
  parameter logic [31:0] ZBUF_BASE      = 32'h0000_0000,
  parameter int unsigned RD_ADDR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_req,
  input  logic [14:0] fill_block_id,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_en,
  input  logic        mem_rd_ack,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic [10:0] cache_wr_addr,
  output logic [31:0] cache_wr_data,
  output logic        cache_wr_en,
  input  logic        cache_wr_ack,
  output logic        cache_wr_done,
  output logic        rd_overflow
);

  localparam int unsigned WORDS  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SLOT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic [ADDR_W-1:0]   blk_base;
  logic [CNT_W-1:0]    iss_cnt;
  logic [CNT_W-1:0]    rcv_cnt;
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DATA_W-1:0]   fifo_mem [WORDS];

  logic                rd_accept_c;
  logic                wr_take_c;
  logic                out_free_c;
  logic                fifo_pop_c;
  logic                bypass_c;
  logic                fifo_push_c;
  logic [CNT_W-1:0]    wr_cnt_nxt_c;

  // Handshake qualifiers; the output stage refills from the FIFO head first,
  // otherwise straight from the returning read so a word lands one cycle after it arrives.
  always_comb begin
    rd_accept_c  = mem_rd_valid && (state == RUN) && (rcv_cnt != iss_cnt);
    wr_take_c    = cache_wr_en && cache_wr_ack;
    out_free_c   = !cache_wr_en || cache_wr_ack;
    fifo_pop_c   = (state == RUN) && out_free_c && (fifo_cnt != '0);
    bypass_c     = (state == RUN) && out_free_c && (fifo_cnt == '0) && rd_accept_c;
    fifo_push_c  = rd_accept_c && !bypass_c;
    wr_cnt_nxt_c = wr_cnt + CNT_W'(wr_take_c);
  end

  // Return-data buffer storage; occupancy is tracked in the control block.
  always_ff @(posedge clk) begin
    if (fifo_push_c) begin
      fifo_mem[wr_ptr] <= mem_rd_data;
    end
  end

  // Fill sequencer: read issue, return buffering, cache write stage and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      slot          <= '0;
      blk_base      <= '0;
      iss_cnt       <= '0;
      rcv_cnt       <= '0;
      wr_cnt        <= '0;
      fifo_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_rd_en     <= 1'b0;
      cache_wr_addr <= '0;
      cache_wr_data <= '0;
      cache_wr_en   <= 1'b0;
      cache_wr_done <= 1'b0;
      rd_overflow   <= 1'b0;
    end else begin
      // Any read return that has no outstanding request is dropped and flagged.
      if (mem_rd_valid && !rd_accept_c) begin
        rd_overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fill_req) begin
            state       <= RUN;
            fill_busy   <= 1'b1;
            slot        <= fill_block_id[SLOT_W-1:0];
            blk_base    <= ZBUF_BASE + {12'b0, fill_block_id, 5'b0};
            mem_rd_addr <= ZBUF_BASE + {12'b0, fill_block_id, 5'b0};
            mem_rd_en   <= 1'b1;
            iss_cnt     <= '0;
            rcv_cnt     <= '0;
            wr_cnt      <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
          end
        end

        RUN: begin
          if (mem_rd_en && mem_rd_ack) begin
            iss_cnt <= iss_cnt + CNT_W'(1);
            if (iss_cnt == CNT_W'(WORDS - 1)) begin
              mem_rd_en <= 1'b0;
            end else begin
              mem_rd_addr <= blk_base + ADDR_W'(iss_cnt + CNT_W'(1)) * ADDR_W'(RD_ADDR_STRIDE);
            end
          end

          if (rd_accept_c) begin
            rcv_cnt <= rcv_cnt + CNT_W'(1);
          end
          if (fifo_push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (fifo_pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
          fifo_cnt <= fifo_cnt + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);
          wr_cnt   <= wr_cnt_nxt_c;

          if (out_free_c) begin
            if (fifo_pop_c) begin
              cache_wr_en   <= 1'b1;
              cache_wr_data <= fifo_mem[rd_ptr];
              cache_wr_addr <= {slot, wr_cnt_nxt_c[PTR_W-1:0]};
            end else if (bypass_c) begin
              cache_wr_en   <= 1'b1;
              cache_wr_data <= mem_rd_data;
              cache_wr_addr <= {slot, wr_cnt_nxt_c[PTR_W-1:0]};
            end else begin
              cache_wr_en   <= 1'b0;
            end
          end

          if (wr_cnt_nxt_c == CNT_W'(WORDS)) begin
            state         <= DONE;
            cache_wr_en   <= 1'b0;
            cache_wr_done <= 1'b1;
            fill_done     <= 1'b1;
          end
        end

        DONE: begin
          state         <= IDLE;
          cache_wr_done <= 1'b0;
          fill_done     <= 1'b0;
          fill_busy     <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zbuf_fill_engine.sv
// tb_zbuf_fill_engine: randomized memory/cache responders with a behavioural fill model.
module tb_zbuf_fill_engine;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_req;
  logic [14:0] fill_block_id;
  logic        fill_busy;
  logic        fill_done;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_en;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [10:0] cache_wr_addr;
  logic [31:0] cache_wr_data;
  logic        cache_wr_en;
  logic        cache_wr_ack;
  logic        cache_wr_done;
  logic        rd_overflow;

  always #5 clk = ~clk;

  zbuf_fill_engine #(.ZBUF_BASE(BASE), .RD_ADDR_STRIDE(4)) dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .fill_block_id(fill_block_id),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
    .cache_wr_en(cache_wr_en), .cache_wr_ack(cache_wr_ack),
    .cache_wr_done(cache_wr_done), .rd_overflow(rd_overflow)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model of the fill: phase 0 idle, 1 running, 2 done cycle.
  int          m_phase = 0;
  logic [14:0] m_blk = '0;
  int          m_iss = 0, m_rcv = 0, m_wr = 0;
  logic        m_ovf = 1'b0;

  // Responder configuration and bookkeeping.
  int mem_ack_mode = 0, mem_lat_mode = 0, cache_ack_mode = 0, stall_left = 0;
  logic spur = 1'b0, rst_at4 = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  logic [31:0] rd_log[$];
  logic [10:0] wr_log[$];
  int done_pulses = 0;
  int t_req = -1, t_rd = -1, t_wr = -1, t_done = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] exp_rd_addr(input logic [14:0] b, input int i);
    return BASE + 32'(b) * 32'd32 + 32'(i) * 32'd4;
  endfunction

  function automatic logic [10:0] exp_wr_addr(input logic [14:0] b, input int i);
    return {b[7:0], 3'(i)};
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, fill_busy, 1'b0);
    chk1({tag, "_fill_done"}, fill_done, 1'b0);
    chk1({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk32({tag, "_rd_addr"}, mem_rd_addr, 32'h0);
    chk1({tag, "_wr_en"}, cache_wr_en, 1'b0);
    chk32({tag, "_wr_addr"}, 32'(cache_wr_addr), 32'h0);
    chk32({tag, "_wr_data"}, cache_wr_data, 32'h0);
    chk1({tag, "_wr_done"}, cache_wr_done, 1'b0);
    chk1({tag, "_ovf"}, rd_overflow, 1'b0);
  endtask

  // One clock cycle: compare outputs against the model, drive responders, advance the model.
  task automatic step(input logic req, input logic [14:0] bid);
    logic e_rd, e_wr, a_r, a_w, v;
    logic [31:0] vd;
    int rdy;
    @(negedge clk);
    if (rst) rst = 1'b0;
    cyc++;

    e_rd = (m_phase == 1) && (m_iss < 8);
    e_wr = (m_phase == 1) && (m_rcv > m_wr);
    chk1("mem_rd_en", mem_rd_en, e_rd);
    if (e_rd) chk32("mem_rd_addr", mem_rd_addr, exp_rd_addr(m_blk, m_iss));
    chk1("cache_wr_en", cache_wr_en, e_wr);
    if (e_wr) begin
      chk32("cache_wr_addr", 32'(cache_wr_addr), 32'(exp_wr_addr(m_blk, m_wr)));
      chk32("cache_wr_data", cache_wr_data, mem_word(exp_rd_addr(m_blk, m_wr)));
    end
    chk1("fill_busy", fill_busy, m_phase != 0);
    chk1("cache_wr_done", cache_wr_done, m_phase == 2);
    chk1("fill_done", fill_done, m_phase == 2);
    chk1("rd_overflow", rd_overflow, m_ovf);

    if (cache_wr_done) done_pulses++;
    if (mem_rd_en && t_rd < 0) t_rd = cyc;
    if (cache_wr_en && t_wr < 0) t_wr = cyc;
    if (cache_wr_done && t_done < 0) t_done = cyc;

    case (mem_ack_mode)
      0: a_r = 1'b1;
      1: a_r = ($urandom_range(0, 1) == 1);
      default: begin
        a_r = 1'b1;
        if (mem_rd_en && m_iss == 2 && stall_left > 0) begin
          a_r = 1'b0;
          stall_left--;
        end
      end
    endcase
    case (cache_ack_mode)
      0: a_w = 1'b1;
      1: a_w = (cyc % 3 == 0);
      default: a_w = ($urandom_range(0, 1) == 1);
    endcase

    v = 1'b0;
    vd = 32'h0;
    if (spur) begin
      v = 1'b1;
      vd = 32'hDEAD_BEEF;
      spur = 1'b0;
    end else if (pend_addr.size() > 0 && pend_rdy[0] <= cyc &&
                 (mem_lat_mode == 0 || $urandom_range(0, 3) != 0)) begin
      v = 1'b1;
      vd = mem_word(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end

    mem_rd_ack    = a_r;
    mem_rd_valid  = v;
    mem_rd_data   = vd;
    cache_wr_ack  = a_w;
    fill_req      = req;
    fill_block_id = bid;

    if (rst_at4 && e_wr && a_w && m_wr == 3) begin
      rst = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      m_phase = 0; m_iss = 0; m_rcv = 0; m_wr = 0; m_ovf = 1'b0;
      pend_addr.delete();
      pend_rdy.delete();
      rst_at4 = 1'b0;
      return;
    end

    if (mem_rd_en && a_r) begin
      rd_log.push_back(mem_rd_addr);
      rdy = cyc + 1 + ((mem_lat_mode == 0) ? 0 : int'($urandom_range(0, 3)));
      if (pend_rdy.size() > 0 && rdy < pend_rdy[$]) rdy = pend_rdy[$];
      pend_addr.push_back(mem_rd_addr);
      pend_rdy.push_back(rdy);
    end
    if (cache_wr_en && a_w) wr_log.push_back(cache_wr_addr);

    case (m_phase)
      0: begin
        if (v) m_ovf = 1'b1;
        if (req) begin
          m_phase = 1; m_blk = bid; m_iss = 0; m_rcv = 0; m_wr = 0; stall_left = 5;
        end
      end
      1: begin
        if (v) begin
          if (m_rcv < m_iss) m_rcv++;
          else m_ovf = 1'b1;
        end
        if (e_rd && a_r) m_iss++;
        if (e_wr && a_w) begin
          m_wr++;
          if (m_wr == 8) m_phase = 2;
        end
      end
      default: begin
        if (v) m_ovf = 1'b1;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic run_fill(input logic [14:0] bid, input int exp_pulses);
    int p0;
    int n;
    p0 = done_pulses;
    n = 0;
    rd_log.delete();
    wr_log.delete();
    t_rd = -1; t_wr = -1; t_done = -1;
    step(1'b1, bid);
    t_req = cyc;
    while (m_phase != 0 && n < 300) begin
      step(1'b0, bid);
      n++;
    end
    chk1("fill_complete", m_phase == 0, 1'b1);
    chk32("done_pulses", 32'(done_pulses - p0), 32'(exp_pulses));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 15'h0);
  endtask

  initial begin
    int p0, n, gap;
    logic [14:0] b;
    rst = 1'b1;
    fill_req = 1'b0; fill_block_id = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; cache_wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Zero-wait memory, immediate cache ack: latency and address pins.
    mem_ack_mode = 0; mem_lat_mode = 0; cache_ack_mode = 0;
    run_fill(15'h0003, 1);
    chk32("t1_rd_lat", 32'(t_rd - t_req), 32'd1);
    chk32("t1_wr_lat", 32'(t_wr - t_req), 32'd3);
    chk32("t1_done_lat", 32'(t_done - t_req), 32'd11);
    chk32("t1_rd_count", 32'(rd_log.size()), 32'd8);
    chk32("t1_wr_count", 32'(wr_log.size()), 32'd8);
    if (rd_log.size() == 8 && wr_log.size() == 8) begin
      chk32("t1_rd_first", rd_log[0], 32'h1000_0060);
      chk32("t1_rd_last", rd_log[7], 32'h1000_007C);
      chk32("t1_wr_first", 32'(wr_log[0]), 32'h018);
      chk32("t1_wr_last", 32'(wr_log[7]), 32'h01F);
    end
    idle(2);

    // Top block ID, cache acks every third cycle.
    cache_ack_mode = 1;
    run_fill(15'h7FFF, 1);
    chk32("t2_rd_count", 32'(rd_log.size()), 32'd8);
    if (rd_log.size() == 8) begin
      chk32("t2_rd_first", rd_log[0], 32'h100F_FFE0);
      chk32("t2_rd_last", rd_log[7], 32'h100F_FFFC);
    end
    if (wr_log.size() > 0) chk32("t2_wr_first", 32'(wr_log[0]), 32'h7F8);
    idle(2);

    // Read ack withheld for five cycles on word 2.
    cache_ack_mode = 0; mem_ack_mode = 2;
    run_fill(15'h0A5C, 1);
    chk32("t3_wr_count", 32'(wr_log.size()), 32'd8);
    idle(2);

    // Reset on the 4th cache ack, then a clean fill.
    mem_ack_mode = 0;
    rst_at4 = 1'b1;
    run_fill(15'h0123, 0);
    idle(2);
    run_fill(15'h0124, 1);
    chk32("t4_wr_count", 32'(wr_log.size()), 32'd8);
    idle(2);

    // Randomized fills.
    mem_ack_mode = 1; mem_lat_mode = 1; cache_ack_mode = 2;
    for (int i = 0; i < 8; i++) begin
      b = 15'($urandom);
      run_fill(b, 1);
      idle(int'($urandom_range(0, 3)));
    end

    // Spurious read return in idle sets the sticky flag; next fill unaffected.
    mem_ack_mode = 0; mem_lat_mode = 0; cache_ack_mode = 0;
    spur = 1'b1;
    idle(2);
    chk1("t5_ovf_set", rd_overflow, 1'b1);
    run_fill(15'h0042, 1);
    chk1("t5_ovf_sticky", rd_overflow, 1'b1);
    idle(2);

    // fill_req held high across a fill: back-to-back fills with one idle cycle.
    p0 = done_pulses; n = 0; gap = 0;
    while (done_pulses - p0 < 2 && n < 300) begin
      step(1'b1, 15'h0155);
      if (done_pulses - p0 == 1 && !fill_busy) gap++;
      n++;
    end
    while (m_phase != 0 && n < 400) begin
      step(1'b0, 15'h0155);
      n++;
    end
    chk32("t6_pulses", 32'(done_pulses - p0), 32'd2);
    chk32("t6_busy_gap", 32'(gap), 32'd1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zbuf_fill_engine.md
Name: zbuf_fill_engine

Overview:
- Memory-side counterpart of the z-buffer cache's line-fill port.
- On a fill request it reads one 4x4 z-block from main memory: 16 z-values x 16 bit = 8 x 32-bit words.
- It buffers the returned words and streams them into the cache over the cache_wr_addr/cache_wr_data/cache_wr_en/cache_wr_ack handshake.
- It closes each fill with a one-cycle cache_wr_done pulse.

Parameters:
- ZBUF_BASE, 32'h0000_0000, byte base address of the z-buffer in main memory.
- RD_ADDR_STRIDE, 4, byte increment between consecutive 32-bit words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- fill_req  in  1  request a block fill; sampled only in IDLE.
- fill_block_id  in  15  block ID = y_cache*num_x_caches + x_cache.
- fill_busy  out  1  high from the cycle after acceptance until return to IDLE.
- fill_done  out  1  one-cycle pulse, coincident with cache_wr_done.
- mem_rd_addr  out  32  word read address.
- mem_rd_en  out  1  read request; held with the address until mem_rd_ack.
- mem_rd_ack  in  1  read request accepted.
- mem_rd_valid  in  1  read data valid; data returns in request order.
- mem_rd_data  in  32  read data; [15:0] = even sub-frag, [31:16] = odd sub-frag.
- cache_wr_addr  out  11  {slot[7:0], word[2:0]}; slot = fill_block_id[7:0].
- cache_wr_data  out  32  word to the cache.
- cache_wr_en  out  1  word valid; held with addr/data until cache_wr_ack.
- cache_wr_ack  in  1  cache accepted the current word.
- cache_wr_done  out  1  one-cycle pulse after the 8th accepted word.
- rd_overflow  out  1  sticky error: mem_rd_valid seen with no outstanding read.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, buffer emptied. Reset mid-fill aborts the fill immediately; no done pulse is produced.
- States:
  - IDLE: when fill_req=1, latch fill_block_id, clear counters, go to RUN. fill_busy=1 from the next cycle.
  - RUN: the read-issue and cache-write processes run concurrently (below). When wr_cnt reaches 8, go to DONE.
  - DONE: cache_wr_done=1 and fill_done=1 for exactly this one cycle, then IDLE. fill_busy is low in the IDLE cycle.
- Read issue:
  - iss_cnt runs 0..8. While iss_cnt<8, mem_rd_en=1 with mem_rd_addr = ZBUF_BASE + {block_id,5'b0} + iss_cnt*RD_ADDR_STRIDE (32-bit wrap).
  - Each cycle with mem_rd_en & mem_rd_ack increments iss_cnt. The next address is presented the following cycle, so back-to-back acks give one read per cycle.
  - mem_rd_en goes low once iss_cnt=8.
- Read return:
  - Data is pushed into an 8-entry FIFO on each mem_rd_valid; rcv_cnt increments.
  - The FIFO cannot overflow, because at most 8 reads are issued per fill.
  - mem_rd_valid when rcv_cnt==iss_cnt, or in IDLE/DONE: data dropped, rd_overflow set. It is cleared only by rst.
- Cache write:
  - When the FIFO is non-empty, cache_wr_en=1 with cache_wr_data = FIFO head and cache_wr_addr = {slot, wr_cnt[2:0]}.
  - A word is registered into the output stage the cycle after it is pushed.
  - On cache_wr_ack with cache_wr_en=1: pop the FIFO and increment wr_cnt. If the FIFO still has data, the next word is presented the next cycle, so cache_wr_en may stay high continuously.
  - cache_wr_ack while cache_wr_en=0 is ignored.
  - Words go to the cache strictly in address order, 0..7.
- Simultaneous push and pop in one cycle: both occur and the FIFO occupancy is unchanged.
- Latency with zero-wait memory (ack with en; valid the cycle after ack) and a cache that acks immediately:
  - fill_req at cycle 0 -> mem_rd_en at cycle 1 -> first valid at cycle 2 -> first cache_wr_en at cycle 3.
  - 8th cache_wr_ack at cycle 10 -> cache_wr_done at cycle 11 -> IDLE at cycle 12.
- fill_req while busy is ignored; it is not queued.

Test Plan:
- Zero-wait memory, immediate cache ack; fill_req with fill_block_id=15'h0003 -> mem_rd_addr 0x60,0x64,...,0x7C on cycles 1-8; cache_wr_addr 11'h018..11'h01F on cycles 3-10 with matching data; cache_wr_done and fill_done pulse once at cycle 11.
- ZBUF_BASE=32'h1000_0000, block 15'h7FFF, cache_wr_ack every 3rd cycle -> addresses 0x100F_FFE0..0x100F_FFFC. cache_wr_en and addr/data are held stable between acks. All 8 words arrive in order; exactly one done pulse.
- mem_rd_ack withheld for 5 cycles on word 2 -> mem_rd_en and mem_rd_addr are held constant. No word is skipped or duplicated; wr_cnt ends at 8.
- rst asserted at the cycle the 4th cache_wr_ack occurs -> all outputs 0 asynchronously and no done pulse. A following fill_req completes a full clean 8-word fill.
- Spurious mem_rd_valid in IDLE -> rd_overflow=1 and stays 1 through a subsequent normal fill. That fill is unaffected.
- fill_req held high across a whole fill -> a second fill starts from the IDLE cycle after DONE; fill_busy shows exactly one low cycle between the two fills.
